// File: rtl/product_bcd_formatter_pkg.sv
// Shared types and the add-3 digit correction used by the BCD formatter.
package calc_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} fmt_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic logic [3:0] bcd_add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: adds 3 to a digit of 5 or more before the shift.
module bcd_add3_digit
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = bcd_add3(d);
endmodule

// File: rtl/product_bcd_formatter.sv
// Signed product -> sign + packed BCD, iterative double-dabble one bit per clock.
// Optional leading-zero blanking when BCD_LEADING_ZERO_BLANK_EN is defined.
module product_bcd_formatter
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_value,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]             out_blank,
  output logic                          busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  fmt_state_t                              state;
  logic [CW-1:0]                           cnt;
  logic [WIDTH-1:0]                        mag;
  logic                                    sign;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]      acc;
  logic [DIGITS-1:0][BCD_DIGIT_W-1:0]      adj;
  logic [BCD_DIGIT_W*DIGITS+WIDTH-1:0]     shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3_digit u_add3 (.d(acc[g]), .q(adj[g]));
  end

  assign shifted = {adj, mag} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mag   <= '0;
      sign  <= 1'b0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign  <= in_value[WIDTH-1];
          // Unsigned magnitude: the most negative input maps to 2**(WIDTH-1).
          mag   <= in_value[WIDTH-1] ? -in_value : in_value;
          acc   <= '0;
          cnt   <= CW'(WIDTH - 1);
          state <= CONV;
        end
        CONV: begin
          {acc, mag} <= shifted;
          cnt        <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  // Outputs are gated so an in-flight accumulator is never visible.
  assign out_neg   = out_valid & sign;
  assign out_bcd   = out_valid ? acc : '0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  always_comb begin
    logic lead;
    blank = '0;
    lead  = out_valid;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead     = lead && (acc[i] == '0);
      blank[i] = lead;
    end
  end
  assign out_blank = blank;
`else
  assign out_blank = '0;
`endif
endmodule

// File: tb/tb_product_bcd_formatter.sv
// Bench for product_bcd_formatter: directed corner cases plus random values
// against a decimal-arithmetic reference model.
module tb_product_bcd_formatter;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_value = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  out_neg;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [DIGITS-1:0]     out_blank;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  product_bcd_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_neg(out_neg), .out_bcd(out_bcd), .out_blank(out_blank), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_mag(input logic [WIDTH-1:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int m);
    logic [4*DIGITS-1:0] r;
    int rem;
    r   = '0;
    rem = m;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_blank(input int m);
    logic [DIGITS-1:0] r;
    r = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DIGITS; i++) begin
      int p;
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      r[i] = (m < p);
    end
`else
    r = '0;
`endif
    return r;
  endfunction

  // One full transaction: accept, measure latency, hold in DONE, handshake.
  task automatic convert(input logic [WIDTH-1:0] v, input int hold, input bit pulse);
    int m, n;
    logic exp_neg;
    logic [4*DIGITS-1:0] exp_bcd;
    logic [DIGITS-1:0] exp_blank;
    m         = ref_mag(v);
    exp_neg   = (int'($signed(v)) < 0);
    exp_bcd   = ref_bcd(m);
    exp_blank = ref_blank(m);

    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_value = v;
    out_ready = 1'b0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_value = '0;
    check("conv_busy", 32'(busy), 32'd1);
    while (!out_valid && n < 4 * WIDTH) begin
      check("conv_no_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency_edges", 32'(n), 32'(WIDTH + 1));
    check("out_valid", 32'(out_valid), 32'd1);
    check("out_neg", 32'(out_neg), 32'(exp_neg));
    check("out_bcd", 32'(out_bcd), 32'(exp_bcd));
    check("out_blank", 32'(out_blank), 32'(exp_blank));
    check("done_in_ready", 32'(in_ready), 32'd0);

    for (int h = 0; h < hold; h++) begin
      if (pulse) begin
        in_valid = (h % 2 == 0);
        in_value = 8'h77;
      end
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_bcd", 32'(out_bcd), 32'(exp_bcd));
      check("hold_neg", 32'(out_neg), 32'(exp_neg));
      check("hold_blank", 32'(out_blank), 32'(exp_blank));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_valid", 32'(out_valid), 32'd0);
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values
    convert(8'h15, 0, 1'b0);
    convert(8'hE8, 0, 1'b0);
    convert(8'h80, 0, 1'b0);
    convert(8'h40, 0, 1'b0);
    convert(8'h00, 0, 1'b0);
    convert(8'h7F, 1, 1'b0);
    convert(8'hFF, 0, 1'b0);

    // Backpressure with a stray in_valid pulse while DONE
    convert(8'h9C, 5, 1'b1);

    // Reset in the 4th conversion cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_neg", 32'(out_neg), 32'd0);
    check("mid_rst_out_bcd", 32'(out_bcd), 32'd0);
    check("mid_rst_out_blank", 32'(out_blank), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abandoned_no_valid", 32'(out_valid), 32'd0);
    end
    convert(8'h31, 0, 1'b0);

    // Random values with random backpressure
    for (int i = 0; i < 40; i++) begin
      convert(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
